// File: rtl/nes_pad_pkg.sv
// Shared types and button indices for the NES pad reader.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } pad_state_t;

  localparam int unsigned NUM_BUTTONS = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Larger of two unsigned values, used to size phase counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_pad_reader_sync_2ff.sv
// Two-flop synchronizer for the asynchronous pad data line.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Resets to 1 so an unsynchronized line reads as "released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Serial NES gamepad reader: latches the pad once per frame, shifts in
// 8 active-low buttons, and publishes held state plus rising-edge pulses.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int unsigned HALF_PERIOD  = 76,
  parameter int unsigned LATCH_CYCLES = 152
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       data,
  output logic       latch,
  output logic       ctrl_clk,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned CNT_MAX = max_u(LATCH_CYCLES, HALF_PERIOD);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);

  pad_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             data_sync;
  logic             btn_bit;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (data),
    .q       (data_sync)
  );

  assign btn_bit = ~data_sync;

  // Read sequencer; pad-facing strobes are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      latch    <= 1'b0;
      ctrl_clk <= 1'b1;
      buttons  <= '0;
      pressed  <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pressed <= '0;
      valid   <= 1'b0;
      case (state)
        IDLE: begin
          latch    <= 1'b0;
          ctrl_clk <= 1'b1;
          busy     <= 1'b0;
          if (frame_tick) begin
            state <= LATCH;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            latch <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          if (cnt == LATCH_LAST) begin
            shift[BTN_A] <= btn_bit;
            idx          <= 3'd1;
            cnt          <= '0;
            state        <= CLK_LOW;
            latch        <= 1'b0;
            ctrl_clk     <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CLK_LOW: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            state    <= CLK_HIGH;
            ctrl_clk <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CLK_HIGH: begin
          if (cnt == HALF_LAST) begin
            shift[idx] <= btn_bit;
            cnt        <= '0;
            if (idx == 3'd7) begin
              state <= DONE;
            end else begin
              idx      <= idx + 3'd1;
              state    <= CLK_LOW;
              ctrl_clk <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          buttons <= shift;
          pressed <= shift & ~buttons;
          valid   <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader with a behavioural pad and timing model.
module tb_nes_pad_reader;

  localparam int HP    = 4;
  localparam int LC    = 8;
  localparam int TOTAL = LC + 14 * HP + 2;  // frame_tick cycle to valid cycle

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       data;
  logic       latch;
  logic       ctrl_clk;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       valid;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  nes_pad_reader #(
    .HALF_PERIOD  (HP),
    .LATCH_CYCLES (LC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .data       (data),
    .latch      (latch),
    .ctrl_clk   (ctrl_clk),
    .buttons    (buttons),
    .pressed    (pressed),
    .valid      (valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pad model: reloads on latch, advances one bit per ctrl_clk rising edge.
  logic [7:0] pad_pattern = 8'h00;
  logic       plugged = 1'b1;
  logic [7:0] snap = 8'h00;
  int         bit_idx = 8;

  always @(posedge latch) begin
    bit_idx <= 0;
    snap    <= pad_pattern;
  end

  always @(posedge ctrl_clk) begin
    if (!latch) bit_idx <= bit_idx + 1;
  end

  assign data = (plugged && bit_idx < 8) ? ~snap[bit_idx[2:0]] : 1'b1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: p counts cycles since the accepted frame_tick cycle (0 = idle).
  int         p = 0;
  logic [7:0] m_snap = 8'h00;
  logic [7:0] m_buttons = 8'h00;
  logic [7:0] m_pressed = 8'h00;
  logic       m_valid = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p         <= 0;
      m_buttons <= 8'h00;
      m_pressed <= 8'h00;
      m_valid   <= 1'b0;
    end else begin
      automatic int         np = 0;
      automatic logic [7:0] ns = m_snap;
      if ((p == 0 || p >= TOTAL) && frame_tick) begin
        np = 1;
        ns = plugged ? pad_pattern : 8'h00;
      end else if (p > 0 && p < TOTAL) begin
        np = p + 1;
      end
      p         <= np;
      m_snap    <= ns;
      m_valid   <= (np == TOTAL);
      m_pressed <= (np == TOTAL) ? (ns & ~m_buttons) : 8'h00;
      if (np == TOTAL) m_buttons <= ns;
    end
  end

  function automatic logic exp_latch(input int q);
    return (q >= 1 && q <= LC);
  endfunction

  function automatic logic exp_busy(input int q);
    return (q >= 1 && q <= TOTAL - 1);
  endfunction

  // ctrl_clk is low during the even-numbered half periods after the latch.
  function automatic logic exp_ctrl(input int q);
    if (q >= LC + 1 && q <= LC + 14 * HP) return (((q - LC - 1) / HP) % 2) == 1;
    return 1'b1;
  endfunction

  // Per-cycle compare against the model, plus event counters for directed checks.
  int   valid_cnt = 0;
  int   latch_rises = 0;
  logic prev_latch = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      check("latch", 8'(latch), 8'(exp_latch(p)));
      check("ctrl_clk", 8'(ctrl_clk), 8'(exp_ctrl(p)));
      check("busy", 8'(busy), 8'(exp_busy(p)));
      check("valid", 8'(valid), 8'(m_valid));
      check("buttons", buttons, m_buttons);
      check("pressed", pressed, m_pressed);
      if (valid) valid_cnt <= valid_cnt + 1;
      if (latch && !prev_latch) latch_rises <= latch_rises + 1;
    end
    prev_latch <= latch;
  end

  task automatic pulse_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  // One full read with hand-computed expectations and pad-protocol checks.
  task automatic do_read(input logic [7:0] pat, input logic plug,
                         input logic [7:0] eb, input logic [7:0] ep);
    int   n = 0;
    int   lat = 0;
    int   lows = 0;
    int   lowcyc = 0;
    logic prev_ck = 1'b1;
    logic got = 1'b0;
    pad_pattern = pat;
    plugged     = plug;
    pulse_tick();
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      if (latch) lat++;
      if (!ctrl_clk) begin
        lowcyc++;
        if (prev_ck) lows++;
      end
      prev_ck = ctrl_clk;
      if (valid) got = 1'b1;
    end
    check("latency", 8'(n), 8'(66));
    check("rd_buttons", buttons, eb);
    check("rd_pressed", pressed, ep);
    check("latch_cycles", 8'(lat), 8'(8));
    check("ctrl_low_pulses", 8'(lows), 8'(7));
    check("ctrl_low_cycles", 8'(lowcyc), 8'(28));
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int vc0;
    int lr0;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_latch", 8'(latch), 8'(0));
    check("rst_ctrl_clk", 8'(ctrl_clk), 8'(1));
    check("rst_busy", 8'(busy), 8'(0));
    check("rst_valid", 8'(valid), 8'(0));
    check("rst_buttons", buttons, 8'h00);
    check("rst_pressed", pressed, 8'h00);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    do_read(8'h81, 1'b1, 8'h81, 8'h81);
    do_read(8'h81, 1'b1, 8'h81, 8'h00);
    do_read(8'h82, 1'b1, 8'h82, 8'h02);
    do_read(8'hFF, 1'b0, 8'h00, 8'h00);
    do_read(8'hFF, 1'b0, 8'h00, 8'h00);
    do_read(8'h81, 1'b1, 8'h81, 8'h81);

    // frame_tick every 10 cycles while busy: one read only.
    pad_pattern = 8'h24;
    vc0 = valid_cnt;
    lr0 = latch_rises;
    for (int i = 0; i < 7; i++) begin
      pulse_tick();
      repeat (8) @(posedge clk);
    end
    repeat (100) @(negedge clk);
    check("busy_valid_count", 8'(valid_cnt - vc0), 8'(1));
    check("busy_latch_count", 8'(latch_rises - lr0), 8'(1));
    check("busy_buttons", buttons, 8'h24);

    // Reset in the middle of the bit-4 high phase.
    pad_pattern = 8'h55;
    pulse_tick();
    n = 0;
    while (n < 38) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_busy", 8'(busy), 8'(1));
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("abort_latch", 8'(latch), 8'(0));
    check("abort_ctrl_clk", 8'(ctrl_clk), 8'(1));
    check("abort_busy", 8'(busy), 8'(0));
    check("abort_buttons", buttons, 8'h00);
    check("abort_valid", 8'(valid), 8'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    vc0 = valid_cnt;
    repeat (100) @(negedge clk);
    check("no_valid_after_abort", 8'(valid_cnt - vc0), 8'(0));
    do_read(8'h10, 1'b1, 8'h10, 8'h10);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
